ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
//  Parametrised N-bit ALU: registered operands, valid/ready handshake on input and result.
//  Same 8 operations as the 8-bit ULA. Multiply is a multi-cycle shift-add unit (one bit
//  per clock), not a combinational array.
//  Sits between the operand register file and the result bus; one operation in flight.
// PARAMETERS
//  N      8   operand width (N >= 2)
//  CNT_W  $clog2(N)+1   iteration counter width (derived; do not override)
// PORTS
//  Tclk       in   1     clock, all state updates on rising edge
//  Tclr       in   1     reset, asynchronous, active-low
//  en         in   1     unit enable; 0 blocks new accepts only
//  in_valid   in   1     operands/opcode valid
//  in_ready   out  1     unit can accept (high only in IDLE with en=1)
//  A_in,B_in  in   N     operands (unsigned unless ULA_SIGNED_EN and sgn=1)
//  selec      in   3     opcode: 000 add,001 sub,010 gt,011 lt,100 ge,101 le,110 eq,111 mul
//  out_valid  out  1     result valid (high only in DONE)
//  out_ready  in   1     consumer takes result
//  S          out  N+1   add/sub/compare result
//  Smulti     out  2N    multiply product
// BEHAVIOUR
//  Reset (Tclr=0, async): state=IDLE; S, Smulti, operand regs, counter = 0; out_valid=0.
//  FSM: IDLE -> EXEC (accept, selec!=111) | MUL (accept, selec==111); EXEC -> DONE;
//   MUL -> DONE when counter reaches N; DONE -> IDLE when out_ready=1, else hold.
//  Accept = in_valid & in_ready on a rising edge: A_in, B_in, selec latched.
//   Inputs are ignored at all other times.
//  EXEC (1 cycle) writes S; Smulti unchanged:
//   add: S = A+B (S[N] = carry). sub: S = {borrow, A-B mod 2^N}; borrow=1 iff A<B.
//   compares: S = {N'b0, flag}, flag per opcode (ge = gt|eq, le = lt|eq).
//  MUL: shift-add, LSB first; N cycles; writes Smulti = A*B exact; S unchanged.
//  Latency: accept edge to out_valid high = 2 edges (ALU ops), N+1 edges (mul).
//  DONE: out_valid=1; S/Smulti stable until the next operation writes them.
//   Handshake completes on the edge with out_valid & out_ready.
//  in_ready=0 in DONE. No accept on the same edge the result is taken;
//   the earliest next accept is the following edge.
//  Output holding: S and Smulti hold their last written value; never tristated or X.
//  en=0 mid-operation: EXEC/MUL/DONE proceed normally; only IDLE accepts are blocked.
//  Reset mid-operation (any state): operation aborted, all outputs 0, no out_valid pulse.
//  Boundaries: A=B=2^N-1 add -> S=2^(N+1)-2; mul -> Smulti=(2^N-1)^2, no truncation;
//   A=0 or B=0 mul still takes N cycles.
//  Invalid state encoding: recovers to IDLE.
// CONFIGURATION
//  ULA_SIGNED_EN defined: extra input port sgn (1 bit), latched on accept.
//   sgn=1: gt/lt/ge/le are two's-complement compares.
//    mul: magnitudes via shift-add, then product negated if signs differ (still N+1 latency).
//    add/sub: S[N] = signed overflow instead of carry/borrow.
//   sgn=0: identical to the unsigned build.
//  ULA_SIGNED_EN undefined: no sgn port; all operations unsigned as above.
// TESTING
//  add A=8'hFF,B=8'h01 -> out_valid 2 edges after accept, S=9'h100.
//  sub A=3,B=5 -> S=9'h1FE (borrow=1). eq A=B=8'h5A -> S=9'h001. le A=7,B=6 -> S=0.
//  mul A=8'hFF,B=8'hFF -> out_valid exactly 9 edges after accept, Smulti=16'hFE01, S unchanged.
//  Handshake: hold out_ready=0 5 cycles -> out_valid/S stable, in_ready=0, new in_valid ignored.
//   Then out_ready=1 -> IDLE next edge.
//  Drop Tclr mid-MUL (cycle 4) -> immediate zero outputs and IDLE.
//   After release: in_ready=1 when en=1; no stale result.
//  ULA_SIGNED_EN, sgn=1: mul A=-3 (8'hFD),B=5 -> Smulti=16'hFFF1.
//   lt 8'h80 vs 8'h01 -> S[0]=1. add 8'h7F+8'h01 -> S[N]=1 (overflow).

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: N-bit sequential ALU with valid/ready handshakes and a one-bit-per-clock shift-add multiplier.
// Defining ULA_SIGNED_EN adds the sgn input and two's-complement compare/overflow/multiply modes.
module ula_seq #(
  parameter int N = 8
) (
  input  logic           Tclk,
  input  logic           Tclr,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A_in,
  input  logic [N-1:0]   B_in,
  input  logic [2:0]     selec,
`ifdef ULA_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N:0]     S,
  output logic [2*N-1:0] Smulti
);
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [N-1:0]     ONE_N    = N'(1);
  localparam logic [2*N-1:0]   ONE_2N   = (2*N)'(1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state;
  logic [N-1:0]     a_r, b_r;
  logic [2:0]       op_r;
  logic             signed_r;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   acc, mcand;
  logic [N-1:0]     mplier;

  logic             in_signed;
  logic             accept;
  logic [N:0]       sum, diff, alu_res;
  logic             add_ovf, sub_ovf, gt, lt, eq;
  logic [N-1:0]     a_mag, b_mag;
  logic [2*N-1:0]   acc_step, product;

`ifdef ULA_SIGNED_EN
  assign in_signed = sgn;
`else
  assign in_signed = 1'b0;
`endif

  assign in_ready = (state == IDLE) && en;
  assign accept   = in_valid && in_ready;

  assign sum     = {1'b0, a_r} + {1'b0, b_r};
  assign diff    = {1'b0, a_r} - {1'b0, b_r};
  assign add_ovf = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
  assign sub_ovf = (a_r[N-1] != b_r[N-1]) && (diff[N-1] != a_r[N-1]);
  assign eq      = (a_r == b_r);
  assign gt      = signed_r ? ($signed(a_r) > $signed(b_r)) : (a_r > b_r);
  assign lt      = signed_r ? ($signed(a_r) < $signed(b_r)) : (a_r < b_r);

  always_comb begin
    alu_res = '0;
    case (op_r)
      3'b000:  alu_res = signed_r ? {add_ovf, sum[N-1:0]} : sum;
      3'b001:  alu_res = signed_r ? {sub_ovf, diff[N-1:0]} : diff;
      3'b010:  alu_res[0] = gt;
      3'b011:  alu_res[0] = lt;
      3'b100:  alu_res[0] = gt | eq;
      3'b101:  alu_res[0] = lt | eq;
      3'b110:  alu_res[0] = eq;
      default: alu_res = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the sign is reapplied to the final sum
  assign a_mag    = (in_signed && A_in[N-1]) ? (~A_in + ONE_N) : A_in;
  assign b_mag    = (in_signed && B_in[N-1]) ? (~B_in + ONE_N) : B_in;
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign product  = neg_r ? (~acc_step + ONE_2N) : acc_step;

  always_ff @(posedge Tclk or negedge Tclr) begin
    if (!Tclr) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      signed_r  <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      S         <= '0;
      Smulti    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r      <= A_in;
            b_r      <= B_in;
            op_r     <= selec;
            signed_r <= in_signed;
            neg_r    <= in_signed && (A_in[N-1] ^ B_in[N-1]);
            mcand    <= {{N{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            state    <= (selec == 3'b111) ? MUL : EXEC;
          end
        end
        EXEC: begin
          S         <= alu_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            Smulti    <= product;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vector table plus handshake, enable and reset-abort sequences for ula_seq (unsigned build).
module tb_ula_seq;
  localparam int N = 8;

  logic           Tclk = 1'b0;
  logic           Tclr;
  logic           en;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A_in;
  logic [N-1:0]   B_in;
  logic [2:0]     selec;
  logic           out_valid;
  logic           out_ready;
  logic [N:0]     S;
  logic [2*N-1:0] Smulti;

  int checks   = 0;
  int failures = 0;
  logic [N:0]     exp_s;
  logic [2*N-1:0] exp_m;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [8:0]  s;
    logic [15:0] m;
  } vec_t;

  vec_t vecs [16];

  ula_seq #(.N(N)) dut (
    .Tclk(Tclk), .Tclr(Tclr), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .selec(selec),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Smulti(Smulti)
  );

  always #5 Tclk = ~Tclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation at a negedge and returns 1ns after its accept edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge Tclk);
    A_in     = a;
    B_in     = b;
    selec    = op;
    in_valid = 1'b1;
    #1 checkOutput("in_ready_idle", in_ready, 1);
    @(posedge Tclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDone(input int exp_lat, input string name);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge Tclk);
      #1 lat++;
    end
    checkOutput(name, lat, exp_lat);
  endtask

  task automatic takeResult();
    @(negedge Tclk);
    out_ready = 1'b1;
    @(posedge Tclk);
    #1 out_ready = 1'b0;
    checkOutput("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    Tclr      = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A_in      = '0;
    B_in      = '0;
    selec     = '0;

    vecs[0]  = '{8'hFF, 8'h01, 3'b000, 9'h100, 16'h0};
    vecs[1]  = '{8'hFF, 8'hFF, 3'b000, 9'h1FE, 16'h0};
    vecs[2]  = '{8'h12, 8'h34, 3'b000, 9'h046, 16'h0};
    vecs[3]  = '{8'h03, 8'h05, 3'b001, 9'h1FE, 16'h0};
    vecs[4]  = '{8'h05, 8'h03, 3'b001, 9'h002, 16'h0};
    vecs[5]  = '{8'h07, 8'h06, 3'b010, 9'h001, 16'h0};
    vecs[6]  = '{8'h06, 8'h07, 3'b010, 9'h000, 16'h0};
    vecs[7]  = '{8'h80, 8'h01, 3'b011, 9'h000, 16'h0};
    vecs[8]  = '{8'h05, 8'h05, 3'b100, 9'h001, 16'h0};
    vecs[9]  = '{8'h07, 8'h06, 3'b101, 9'h000, 16'h0};
    vecs[10] = '{8'h5A, 8'h5A, 3'b110, 9'h001, 16'h0};
    vecs[11] = '{8'h5A, 8'h5B, 3'b110, 9'h000, 16'h0};
    vecs[12] = '{8'hFF, 8'hFF, 3'b111, 9'h000, 16'hFE01};
    vecs[13] = '{8'h00, 8'h37, 3'b111, 9'h000, 16'h0000};
    vecs[14] = '{8'h0D, 8'h0B, 3'b111, 9'h000, 16'h008F};
    vecs[15] = '{8'h80, 8'h02, 3'b111, 9'h000, 16'h0100};

    #12;
    checkOutput("reset_S", S, 0);
    checkOutput("reset_Smulti", Smulti, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    @(negedge Tclk);
    Tclr  = 1'b1;
    exp_s = '0;
    exp_m = '0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
      if (vecs[i].op == 3'b111) begin
        waitDone(N + 1, $sformatf("vec%0d_latency", i));
        exp_m = vecs[i].m;
      end else begin
        waitDone(2, $sformatf("vec%0d_latency", i));
        exp_s = vecs[i].s;
      end
      checkOutput($sformatf("vec%0d_S", i), S, exp_s);
      checkOutput($sformatf("vec%0d_Smulti", i), Smulti, exp_m);
      takeResult();
    end

    // Result held for 5 cycles while a new request is offered and must be ignored
    applyStimulus(8'h03, 8'h05, 3'b001);
    waitDone(2, "hold_latency");
    exp_s = 9'h1FE;
    for (int c = 0; c < 5; c++) begin
      @(negedge Tclk);
      in_valid = 1'b1;
      A_in     = 8'h11;
      B_in     = 8'h22;
      selec    = 3'b000;
      @(posedge Tclk);
      #1;
      checkOutput($sformatf("hold%0d_out_valid", c), out_valid, 1);
      checkOutput($sformatf("hold%0d_S", c), S, exp_s);
      checkOutput($sformatf("hold%0d_in_ready", c), in_ready, 0);
    end
    @(negedge Tclk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge Tclk);
    #1 out_ready = 1'b0;
    checkOutput("hold_release_out_valid", out_valid, 0);
    checkOutput("hold_release_in_ready", in_ready, 1);
    repeat (3) @(posedge Tclk);
    #1;
    checkOutput("hold_ignored_out_valid", out_valid, 0);
    checkOutput("hold_ignored_S", S, exp_s);

    // en=0 blocks accepts in IDLE
    @(negedge Tclk);
    en       = 1'b0;
    in_valid = 1'b1;
    A_in     = 8'h01;
    B_in     = 8'h01;
    selec    = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(posedge Tclk);
      #1;
      checkOutput($sformatf("en_off%0d_in_ready", c), in_ready, 0);
      checkOutput($sformatf("en_off%0d_out_valid", c), out_valid, 0);
    end
    @(negedge Tclk);
    in_valid = 1'b0;
    en       = 1'b1;

    // en=0 after accept does not stall the operation
    applyStimulus(8'h20, 8'h30, 3'b000);
    en = 1'b0;
    waitDone(2, "en_mid_latency");
    exp_s = 9'h050;
    checkOutput("en_mid_S", S, exp_s);
    takeResult();
    en = 1'b1;

    // Reset dropped in the 4th multiply cycle aborts the operation
    applyStimulus(8'hFF, 8'hFF, 3'b111);
    repeat (3) @(posedge Tclk);
    #2 Tclr = 1'b0;
    #1;
    checkOutput("abort_S", S, 0);
    checkOutput("abort_Smulti", Smulti, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    exp_s = '0;
    exp_m = '0;
    @(negedge Tclk);
    Tclr = 1'b1;
    #1 checkOutput("abort_in_ready", in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(posedge Tclk);
        #1 if (out_valid) seen = 1'b1;
      end
      checkOutput("abort_no_stale_valid", seen, 0);
    end
    checkOutput("abort_Smulti_after", Smulti, 0);

    applyStimulus(8'h0D, 8'h0B, 3'b111);
    waitDone(N + 1, "recover_latency");
    checkOutput("recover_Smulti", Smulti, 16'h008F);
    checkOutput("recover_S", S, exp_s);
    takeResult();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
